// File: rtl/ysyx_23060020_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, size codes
// and the byte-offset-to-bit-shift conversion.
package ysyx_23060020_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  function automatic logic [4:0] off_shamt(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  // Unknown size codes are treated as misaligned so they never reach the bus.
  function automatic logic misaligned(input logic [3:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060020_lsu_ext.sv
// Load data alignment: shifts the bus word down to the addressed byte lane
// and sign- or zero-extends byte/half results.
module ysyx_23060020_lsu_ext
  import ysyx_23060020_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [3:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> off_shamt(off);
    case (size)
      SZ_B:    data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060020_lsu.sv
// Load/store unit: accepts one access at a time, issues a single word-aligned
// bus request, waits (bounded by TIMEOUT) for the response and returns the result.
module ysyx_23060020_lsu
  import ysyx_23060020_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_wen,
  input  logic [3:0]  in_size,
  input  logic        in_signed,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [31:0]   addr_reg, wdata_reg, rdata_reg;
  logic          wen_reg, sgn_reg, err_reg;
  logic [3:0]    size_reg;
  logic [CW-1:0] cnt_reg;
  logic          accept, timeout, busy;
  logic [31:0]   ext_data;

  ysyx_23060020_lsu_ext u_ext (
    .rdata    (mem_rdata),
    .off      (addr_reg[1:0]),
    .size     (size_reg),
    .sign_ext (sgn_reg),
    .data     (ext_data)
  );

  assign in_ready = (state_reg == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_reg == REQ) || (state_reg == WAIT);
  assign timeout  = busy && (cnt_reg == CW'(TIMEOUT));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = misaligned(in_size, in_addr[1:0]) ? DONE : REQ;
      REQ:  if (timeout) state_next = DONE;
            else if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_resp_valid || timeout) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are forced to zero outside an active request.
  assign mem_req_valid = (state_reg == REQ) && !timeout;
  assign mem_addr      = mem_req_valid ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign mem_wen       = mem_req_valid && wen_reg;
  assign mem_wstrb     = (mem_req_valid && wen_reg) ? (size_reg << addr_reg[1:0]) : 4'd0;
  assign mem_wdata     = mem_req_valid ? (wdata_reg << off_shamt(addr_reg[1:0])) : 32'd0;

  assign out_valid = (state_reg == DONE);
  assign out_rdata = out_valid ? rdata_reg : 32'd0;
  assign out_err   = out_valid && err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      wen_reg   <= 1'b0;
      size_reg  <= 4'd0;
      sgn_reg   <= 1'b0;
      cnt_reg   <= '0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= in_addr;
        wdata_reg <= in_wdata;
        wen_reg   <= in_wen;
        size_reg  <= in_size;
        sgn_reg   <= in_signed;
        cnt_reg   <= '0;
        rdata_reg <= 32'd0;
        err_reg   <= misaligned(in_size, in_addr[1:0]);
      end else if (state_reg == WAIT && mem_resp_valid) begin
        // A response wins over a timeout landing in the same cycle.
        rdata_reg <= wen_reg ? 32'd0 : ext_data;
        err_reg   <= mem_resp_err;
      end else if (timeout) begin
        rdata_reg <= 32'd0;
        err_reg   <= 1'b1;
      end else if (busy) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Directed bench for the LSU: an arithmetic reference model checked every
// cycle by a monitor, plus literal expectations for the key scenarios.
module tb_ysyx_23060020_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_signed;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_size;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  always #5 clk = ~clk;

  ysyx_23060020_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_wen(in_wen), .in_size(in_size), .in_signed(in_signed),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  logic        txn_active = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen, m_sgn, m_rerr, m_respond;
  logic [3:0]  m_size;

  function automatic int nbytes(input logic [3:0] s);
    if (s == 4'b0001) return 1;
    if (s == 4'b0011) return 2;
    if (s == 4'b1111) return 4;
    return 0;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [3:0] s);
    int n = nbytes(s);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] exp_maddr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [31:0] exp_wstrb(input logic [31:0] a, input logic [3:0] s, input logic w);
    int n = nbytes(s);
    if (!w) return 32'd0;
    return 32'((2 ** n - 1) * (2 ** (a % 4)));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] a, input logic [31:0] d);
    longint p = longint'(d) * (longint'(1) << (8 * (a % 4)));
    return 32'(p);
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] a, input logic [3:0] s,
                                          input logic w, input logic sg, input logic resp,
                                          input logic [31:0] rd);
    int n = nbytes(s);
    longint v;
    if (is_mis(a, s) || w || !resp) return 32'd0;
    v = (longint'(rd) / (longint'(1) << (8 * (a % 4)))) % (longint'(1) << (8 * n));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (!rst && txn_active) begin
      if (is_mis(m_addr, m_size)) begin
        chk("no_mem_req_when_misaligned", {31'd0, mem_req_valid}, 32'd0);
      end else if (mem_req_valid) begin
        chk("mem_addr", mem_addr, exp_maddr(m_addr));
        chk("mem_wstrb", {28'd0, mem_wstrb}, exp_wstrb(m_addr, m_size, m_wen));
        chk("mem_wdata", mem_wdata, exp_wdata(m_addr, m_wdata));
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, m_wen});
      end
      if (out_valid) begin
        chk("out_rdata", out_rdata, exp_out(m_addr, m_size, m_wen, m_sgn, m_respond, m_rdata));
        chk("out_err", {31'd0, out_err},
            {31'd0, is_mis(m_addr, m_size) || !m_respond || m_rerr});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input logic [3:0] s, input logic sg, input logic [31:0] rd,
                         input logic re, input logic resp, input int hold,
                         output logic [31:0] g_maddr, output logic [31:0] g_wstrb,
                         output logic [31:0] g_wdata, output logic [31:0] g_rdata,
                         output logic [31:0] g_err);
    int n;
    bit mis = is_mis(a, s);
    g_maddr = 0; g_wstrb = 0; g_wdata = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_txn", {31'd0, in_ready}, 32'd1);
    m_addr = a; m_wdata = wd; m_wen = w; m_size = s; m_sgn = sg;
    m_rdata = rd; m_rerr = re; m_respond = resp; txn_active = 1'b1;
    in_valid = 1; in_addr = a; in_wdata = wd; in_wen = w; in_size = s; in_signed = sg;
    @(posedge clk); #1;
    in_valid = 0;
    if (!mis) begin
      n = 0;
      while (!mem_req_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("mem_req_seen", {31'd0, mem_req_valid}, 32'd1);
      g_maddr = mem_addr; g_wstrb = {28'd0, mem_wstrb}; g_wdata = mem_wdata;
      @(posedge clk); #1;
      if (resp) begin
        mem_resp_valid = 1; mem_rdata = rd; mem_resp_err = re;
        @(posedge clk); #1;
        mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
      end
    end
    n = 0;
    while (!out_valid && n < (mis ? 2 : 20)) begin @(posedge clk); #1; n++; end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    g_rdata = out_rdata; g_err = {31'd0, out_err};
    repeat (hold) begin
      @(posedge clk); #1;
      chk("out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_out_ready", {30'd0, in_ready, out_valid}, 32'd2);
    txn_active = 1'b0;
    $display("txn addr=0x%08h wen=%0d size=%b signed=%0d -> rdata=0x%08h err=%0d",
             a, w, s, sg, g_rdata, g_err[0]);
  endtask

  logic [31:0] ga, gs, gw, gr, ge;

  initial begin
    rst = 1; in_valid = 0; in_addr = 0; in_wdata = 0; in_wen = 0; in_size = 0; in_signed = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0; out_ready = 0;
    repeat (2) @(posedge clk); #1;
    chk("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("reset_ctrl_outputs", {26'd0, out_valid, out_err, mem_req_valid, mem_wen, mem_wstrb != 0}, 32'd0);
    chk("reset_out_rdata", out_rdata, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // store byte at offset 3
    run_txn(32'h80000003, 32'h000000AB, 1, 4'b0001, 0, 0, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("sb_mem_addr", ga, 32'h80000000);
    chk("sb_wstrb", gs, 32'h8);
    chk("sb_wdata", gw, 32'hAB000000);
    chk("sb_err", ge, 32'd0);

    // load half, signed and unsigned
    run_txn(32'h80000002, 0, 0, 4'b0011, 1, 32'h8001FFFF, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("lh_signed", gr, 32'hFFFF8001);
    run_txn(32'h80000002, 0, 0, 4'b0011, 0, 32'h8001FFFF, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("lh_unsigned", gr, 32'h00008001);

    // misaligned word: no bus request, error result
    run_txn(32'h80000001, 0, 0, 4'b1111, 0, 0, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("mis_word_err", ge, 32'd1);

    // timeout with no response, result held for 3 cycles
    run_txn(32'h80000000, 0, 0, 4'b1111, 0, 0, 0, 0, 3, ga, gs, gw, gr, ge);
    chk("timeout_err", ge, 32'd1);
    chk("timeout_rdata", gr, 32'd0);

    // signed byte loads across all lanes
    for (int i = 0; i < 4; i++) begin
      run_txn(32'h80000010 + i, 0, 0, 4'b0001, 1, 32'h80FF7F01, 0, 1, 0, ga, gs, gw, gr, ge);
      if (i == 3) chk("lb_lane3", gr, 32'hFFFFFF80);
      if (i == 1) chk("lb_lane1", gr, 32'h0000007F);
    end
    run_txn(32'h80000012, 0, 0, 4'b0001, 0, 32'h80FF7F01, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("lbu_lane2", gr, 32'h000000FF);

    // store half, store word, bus error, bad size code, misaligned half
    run_txn(32'h80000022, 32'h00001234, 1, 4'b0011, 0, 0, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("sh_wstrb", gs, 32'hC);
    chk("sh_wdata", gw, 32'h12340000);
    run_txn(32'h80000024, 32'hCAFEF00D, 1, 4'b1111, 0, 0, 0, 1, 1, ga, gs, gw, gr, ge);
    chk("sw_wstrb", gs, 32'hF);
    run_txn(32'h80000030, 0, 0, 4'b1111, 0, 32'h0, 1, 1, 0, ga, gs, gw, gr, ge);
    chk("bus_err", ge, 32'd1);
    run_txn(32'h80000040, 32'h55, 1, 4'b0111, 0, 0, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("bad_size_err", ge, 32'd1);
    run_txn(32'h80000043, 0, 0, 4'b0011, 1, 0, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("mis_half_err", ge, 32'd1);

    // reset while waiting for a response, then a late response
    in_valid = 1; in_addr = 32'h80000004; in_wen = 0; in_size = 4'b1111; in_signed = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
    rst = 1; #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mid_ctrl", {26'd0, out_valid, out_err, mem_req_valid, mem_wen, mem_wstrb != 0}, 32'd0);
    chk("rst_mid_data", out_rdata | mem_addr | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
    mem_resp_valid = 1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_resp_valid = 0; mem_rdata = 0;
    repeat (2) begin
      chk("late_resp_ignored", {30'd0, in_ready, out_valid}, 32'd2);
      @(posedge clk); #1;
    end
    run_txn(32'h80000000, 0, 0, 4'b1111, 0, 32'h12345678, 0, 1, 0, ga, gs, gw, gr, ge);
    chk("lw_after_reset", gr, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
